// File: rtl/down_timer_pkg.sv
// Shared types and defaults for the loadable down-counting timer.
package down_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_WIDTH    = 4;
  localparam int unsigned DEFAULT_PRESCALE = 4;

endpackage

// File: rtl/down_timer_tick.sv
// Prescaler for down_timer: pulses tick once every PRESCALE enabled cycles.
// Only instantiated when DOWN_TIMER_PRESCALE_EN is defined.
module down_timer_tick
  import down_timer_pkg::*;
#(
  parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_cnt;

  assign tick = enable && (r_cnt == LAST);

  // Clear wins over enable so a fresh load or abort restarts a full period.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= tick ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/down_timer.sv
// Loadable down-counting timer with one-shot / auto-reload modes, pause and stop.
// Define DOWN_TIMER_PRESCALE_EN to decrement once every PRESCALE cycles instead of every cycle.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             load_auto,
  input  logic             pause,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("down_timer: PRESCALE must be at least 1");
  end

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_auto;
  logic             r_done;
  logic             w_tick;

`ifdef DOWN_TIMER_PRESCALE_EN
  logic w_tick_clear;
  logic w_tick_en;

  assign w_tick_clear = (load_valid && (r_state == IDLE)) || (stop && (r_state == RUN));
  assign w_tick_en    = (r_state == RUN) && !pause;

  down_timer_tick #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (w_tick_clear),
    .enable(w_tick_en),
    .tick  (w_tick)
  );
`else
  assign w_tick = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_auto   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (load_valid) begin
            r_count  <= load_value;
            r_reload <= load_value;
            r_auto   <= load_auto;
            // A zero load expires immediately without ever entering RUN.
            if (load_value != '0) begin
              r_state <= RUN;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (stop) begin
            r_state <= IDLE;
            r_count <= '0;
          end else if (w_tick && !pause) begin
            if (r_count == WIDTH'(1)) begin
              r_done <= 1'b1;
              if (r_auto) begin
                r_count <= r_reload;
              end else begin
                r_count <= '0;
                r_state <= IDLE;
              end
            end else begin
              r_count <= r_count - WIDTH'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign load_ready = (r_state == IDLE);
  assign busy       = (r_state == RUN);
  assign count      = r_count;
  assign done       = r_done;

endmodule
